// File: rtl/signal_pattern_checker.sv
// Recovers step timing from a serial blink pattern and checks it step by step against PATTERN.
// Optional: define SPC_GLITCH_FILTER_EN to insert a 3-cycle stability filter after the synchroniser.
module signal_pattern_checker #(
  parameter int unsigned        STEP_CYCLES = 5000000,
  parameter int unsigned        PAT_LEN     = 12,
  parameter logic [PAT_LEN-1:0] PATTERN     = 12'b100101000010
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSIG,
  output logic       oLOCK,
  output logic [3:0] oSTEP,
  output logic       oMATCH,
  output logic       oERR,
  output logic [7:0] oERRCNT
);

  localparam int unsigned     PH_W      = $clog2(STEP_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(STEP_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_MID    = PH_W'(STEP_CYCLES / 2);
  localparam logic [3:0]      STEP_LAST = 4'(PAT_LEN - 1);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_e;

  logic sync1_q, sync2_q;
  logic s;

  // NOTE: non-blocking assignments make each stage take the previous stage's old value,
  // so the chain really is two flops deep regardless of statement order.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= iSIG;
      sync2_q <= sync1_q;
    end
  end

`ifdef SPC_GLITCH_FILTER_EN
  logic       filt_q;
  logic [1:0] hold_q;

  // Output follows the input only after it has differed for three consecutive cycles.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      filt_q <= 1'b0;
      hold_q <= 2'd0;
    end else if (sync2_q == filt_q) begin
      hold_q <= 2'd0;
    end else if (hold_q == 2'd2) begin
      filt_q <= sync2_q;
      hold_q <= 2'd0;
    end else begin
      hold_q <= hold_q + 2'd1;
    end
  end

  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  state_e             state_q;
  logic               s_dly_q;
  logic [PH_W-1:0]    ph_q;
  logic [PAT_LEN-1:0] win_q;
  logic [3:0]         step_q;
  logic               match_q;
  logic               err_q;
  logic [7:0]         errcnt_q;

  logic               edge_w;
  logic               sample_w;
  logic               exp_bit;
  logic [PAT_LEN-1:0] win_d;

  assign edge_w   = s ^ s_dly_q;
  assign sample_w = (state_q != IDLE) && (ph_q == PH_MID);
  assign win_d    = {win_q[PAT_LEN-2:0], s};
  assign exp_bit  = PATTERN[STEP_LAST - step_q];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      s_dly_q  <= 1'b0;
      ph_q     <= '0;
      win_q    <= '0;
      step_q   <= 4'd0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      s_dly_q <= s;
      match_q <= 1'b0;
      err_q   <= 1'b0;

      // An edge re-aligns the step phase; it wins over both wrap and increment.
      if (state_q == IDLE || edge_w || ph_q == PH_LAST) ph_q <= '0;
      else                                              ph_q <= ph_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (edge_w) begin
            state_q <= HUNT;
            win_q   <= '0;
          end
        end
        HUNT: begin
          if (sample_w) begin
            win_q <= win_d;
            if (win_d == PATTERN) begin
              match_q <= 1'b1;
              step_q  <= 4'd0;
              state_q <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (sample_w) begin
            if (s == exp_bit) begin
              win_q <= win_d;
              if (step_q == STEP_LAST) begin
                step_q  <= 4'd0;
                match_q <= 1'b1;
              end else begin
                step_q <= step_q + 4'd1;
              end
            end else begin
              err_q   <= 1'b1;
              win_q   <= '0;
              state_q <= HUNT;
              if (errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oLOCK   = (state_q == LOCKED);
  assign oSTEP   = oLOCK ? step_q : 4'd0;
  assign oMATCH  = match_q;
  assign oERR    = err_q;
  assign oERRCNT = errcnt_q;

endmodule

// File: tb/tb_signal_pattern_checker.sv
// Directed bench for signal_pattern_checker (STEP_CYCLES=8): expected match/error events are
// queued with their due cycle when a frame is issued and a monitor pops them as the DUT pulses.
module tb_signal_pattern_checker;

  localparam int         STEP = 8;
  localparam int         PLEN = 12;
  localparam logic [11:0] PAT = 12'b100101000010;
`ifdef SPC_GLITCH_FILTER_EN
  localparam int         LAT  = 3;
`else
  localparam int         LAT  = 0;
`endif

  typedef enum logic {EV_MATCH, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cycle;
    logic     lock;
    int       errcnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig = 1'b0;
  logic       lock, match, err;
  logic [3:0] step;
  logic [7:0] errcnt;

  signal_pattern_checker #(
    .STEP_CYCLES(STEP),
    .PAT_LEN    (PLEN),
    .PATTERN    (PAT)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .iSIG   (sig),
    .oLOCK  (lock),
    .oSTEP  (step),
    .oMATCH (match),
    .oERR   (err),
    .oERRCNT(errcnt)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  exp_errs = 0;
  int  mode     = 0;   // 0: no step checks, 1: hunting, 2: locked
  int  mbase    = 0;
  bit  g_en     = 1'b0;
  int  g_a      = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_ev(input ev_kind_e kind, input int cycle, input bit lk, input int cnt);
    ev_t e;
    e.kind   = kind;
    e.cycle  = cycle;
    e.lock   = lk;
    e.errcnt = (cnt > 255) ? 255 : cnt;
    exp_q.push_back(e);
  endtask

  task automatic drive_step(input logic b, input int len);
    sig = b;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int n_steps, input int bad_step, input int long_step,
                             input int glitch_step);
    for (int j = 0; j < n_steps; j++) begin
      logic b;
      b = PAT[PLEN-1-j];
      if (j == bad_step) b = ~b;
      if (j == glitch_step) begin
        sig = b;
        @(posedge clk); #1;
        sig = 1'b1;
        @(posedge clk); #1;
        drive_step(b, STEP - 2);
      end else begin
        drive_step(b, (j == long_step) ? STEP + 1 : STEP);
      end
    end
  endtask

  // Monitor: event scoreboard plus periodic step/lock checks.
  always @(negedge clk) begin
    if (rst_n && (match || err)) begin
      check("match_err_exclusive", int'(match && err), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event_queue_size", exp_q.size(), 1);
      end else begin
        mon_ev = exp_q.pop_front();
        check("event_kind_is_err", int'(err), int'(mon_ev.kind == EV_ERR));
        check("event_cycle", cyc, mon_ev.cycle);
        check("event_lock", int'(lock), int'(mon_ev.lock));
        check("event_errcnt", int'(errcnt), mon_ev.errcnt);
      end
    end
    if (mode == 1 && ((cyc - mbase) % STEP) == 4) begin
      check("hunt_lock", int'(lock), 0);
      check("hunt_step", int'(step), 0);
    end
    if (mode == 2 && (cyc - mbase) >= 0 && ((cyc - mbase) % STEP) == 4) begin
      check("locked_lock", int'(lock), 1);
      check("locked_step", int'(step), ((cyc - mbase) / STEP) % PLEN);
    end
    if (g_en && cyc == g_a - 1) check("glitch_step_before", int'(step), 9);
    if (g_en && cyc == g_a)     check("glitch_step_after", int'(step), 10);
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    sig   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      sig = ~sig;
    end
    check("rst_lock", int'(lock), 0);
    check("rst_step", int'(step), 0);
    check("rst_match", int'(match), 0);
    check("rst_err", int'(err), 0);
    check("rst_errcnt", int'(errcnt), 0);

    sig = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_step(1'b0, 20);
    check("idle_lock", int'(lock), 0);
    check("idle_step", int'(step), 0);
    check("idle_errcnt", int'(errcnt), 0);

    // Frame 1 (hunt) and frame 2 (locked): match due 96 cycles after each frame start.
    k = cyc; mode = 1; mbase = k;
    push_ev(EV_MATCH, k + 96 + LAT, 1'b1, 0);
    drive_frame(PLEN, -1, -1, -1);
    k = cyc; mode = 2; mbase = k + LAT;
    push_ev(EV_MATCH, k + 96 + LAT, 1'b1, 0);
    drive_frame(PLEN, -1, -1, -1);

    // Frame 3: step 4 forced high, error one cycle after its sample.
    k = cyc; mode = 0; exp_errs = 1;
    push_ev(EV_ERR, k + 40 + LAT, 1'b0, exp_errs);
    drive_frame(PLEN, 4, -1, -1);
    check("after_err_lock", int'(lock), 0);
    check("after_err_errcnt", int'(errcnt), 1);

    // Frame 4 relocks at its end, frame 5 stays locked.
    k = cyc; mode = 1; mbase = k;
    push_ev(EV_MATCH, k + 96 + LAT, 1'b1, exp_errs);
    drive_frame(PLEN, -1, -1, -1);
    k = cyc; mode = 2; mbase = k + LAT;
    push_ev(EV_MATCH, k + 96 + LAT, 1'b1, exp_errs);
    drive_frame(PLEN, -1, -1, -1);

    // Frame 6: step 2 stretched to 9 cycles; the step-3 edge re-syncs the phase.
    k = cyc; mode = 0;
    push_ev(EV_MATCH, k + 97 + LAT, 1'b1, exp_errs);
    drive_frame(PLEN, -1, 2, -1);
    k = cyc; mode = 2; mbase = k + LAT;
    push_ev(EV_MATCH, k + 96 + LAT, 1'b1, exp_errs);
    drive_frame(PLEN, -1, -1, -1);

    // Frame 8: one-cycle pulse early in step 9; the late sample must still read 0.
    k = cyc; mode = 0;
    g_a = k + 82 + ((LAT > 0) ? 1 : 0);
    g_en = 1'b1;
    push_ev(EV_MATCH, k + 96 + LAT, 1'b1, exp_errs);
    drive_frame(PLEN, -1, -1, 9);
    g_en = 1'b0;

    // 300 errors: wrong step 0 from lock, then a clean frame to relock.
    for (int n = 0; n < 300; n++) begin
      k = cyc; exp_errs++;
      push_ev(EV_ERR, k + 8 + LAT, 1'b0, exp_errs);
      drive_step(1'b0, STEP);
      k = cyc;
      push_ev(EV_MATCH, k + 96 + LAT, 1'b1, exp_errs);
      drive_frame(PLEN, -1, -1, -1);
    end
    check("errcnt_saturated", int'(errcnt), 255);
    check("sat_lock", int'(lock), 1);

    // Reset in the middle of a locked frame clears everything at once.
    drive_frame(6, -1, -1, -1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_lock", int'(lock), 0);
    check("midrst_step", int'(step), 0);
    check("midrst_match", int'(match), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_errcnt", int'(errcnt), 0);
    sig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_step(1'b0, 10);
    check("post_rst_lock", int'(lock), 0);
    exp_errs = 0;
    k = cyc;
    push_ev(EV_MATCH, k + 96 + LAT, 1'b1, 0);
    drive_frame(PLEN, -1, -1, -1);
    drive_step(1'b0, 5);
    check("events_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
